// File: rtl/tiled_matmul_engine.sv
// Tile compute unit: fetches A (ROW x KDIM) and B (KDIM x COL) over granted buses, runs C = A*B + result_in.
// Define SATURATE_EN to clamp each result to the signed WIDTH range; otherwise results wrap.

module tme_mac_cell #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] psum,
  output logic [WIDTH-1:0] res
);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc, prod_x, sum;
  logic signed [2*WIDTH-1:0]   prod;
  logic        [WIDTH-1:0]     fit;

  assign prod   = $signed(a) * $signed(b);
  assign prod_x = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign sum    = acc + {{(ACC_WIDTH-WIDTH){psum[WIDTH-1]}}, psum};

`ifdef SATURATE_EN
  always_comb begin
    fit = sum[WIDTH-1:0];
    if (sum > MAXV)      fit = MAXV[WIDTH-1:0];
    else if (sum < MINV) fit = MINV[WIDTH-1:0];
  end
`else
  assign fit = sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (clr)       acc <= '0;
      else if (step) acc <= acc + prod_x;
      if (load)      res <= fit;
    end
  end
endmodule

module tiled_matmul_engine #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int KDIM      = 8,
  parameter int I_INDEX   = 0,
  parameter int J_INDEX   = 0,
  parameter int K_INDEX   = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                grant_in,
  input  logic                                grant_w,
  input  logic [WIDTH-1:0]                    Data_in_a,
  input  logic [WIDTH-1:0]                    Data_in_b,
  input  logic [0:ROW*COL-1][WIDTH-1:0]       result_in,
  output logic [0:ROW*COL-1][WIDTH-1:0]       result_out,
  output logic                                req_in,
  output logic                                req_w,
  output logic                                Done,
  output logic [7:0]                          i,
  output logic [7:0]                          j,
  output logic [7:0]                          k
);
  localparam int NA   = ROW*KDIM;
  localparam int NB   = KDIM*COL;
  localparam int NMAX = (NA > NB) ? NA : NB;
  localparam int LW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int AW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int KW   = (KDIM > 1) ? $clog2(KDIM) : 1;
  localparam logic [LW-1:0] A_LAST = LW'(NA-1);
  localparam logic [LW-1:0] B_LAST = LW'(NB-1);
  localparam logic [KW-1:0] K_LAST = KW'(KDIM-1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    ld_cnt;
  logic [KW-1:0]    k_cnt;
  logic             a_wr, b_wr, clr, step, load;
  logic [WIDTH-1:0] a_buf [2**AW];
  logic [WIDTH-1:0] b_buf [2**BW];

  assign i = 8'(I_INDEX);
  assign j = 8'(J_INDEX);
  assign k = 8'(K_INDEX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_in    = 1'b0;
    req_w     = 1'b0;
    Done      = 1'b0;
    a_wr      = 1'b0;
    b_wr      = 1'b0;
    clr       = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE:    if (en) state_nxt = LOAD_A;
      LOAD_A: begin
        req_in = 1'b1;
        a_wr   = grant_in;
        if (grant_in && ld_cnt == A_LAST) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        req_w = 1'b1;
        b_wr  = grant_w;
        if (grant_w && ld_cnt == B_LAST) begin
          state_nxt = COMPUTE;
          clr       = 1'b1;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (k_cnt == K_LAST) state_nxt = ACCUM;
      end
      ACCUM: begin
        load      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (en) state_nxt = LOAD_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shared address counter serves both load phases; it wraps to 0 on each phase's last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= '0;
      k_cnt  <= '0;
    end else begin
      if ((a_wr && ld_cnt == A_LAST) || (b_wr && ld_cnt == B_LAST)) ld_cnt <= '0;
      else if (a_wr || b_wr)                                         ld_cnt <= ld_cnt + 1'b1;
      if (clr)       k_cnt <= '0;
      else if (step) k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (a_wr && !rst) a_buf[AW'(ld_cnt)] <= Data_in_a;
    if (b_wr && !rst) b_buf[BW'(ld_cnt)] <= Data_in_b;
  end

  for (genvar r = 0; r < ROW; r++) begin : g_row
    for (genvar c = 0; c < COL; c++) begin : g_col
      tme_mac_cell #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (step),
        .load (load),
        .a    (a_buf[AW'(r*KDIM) + AW'(k_cnt)]),
        .b    (b_buf[BW'(k_cnt) * BW'(COL) + BW'(c)]),
        .psum (result_in[r*COL+c]),
        .res  (result_out[r*COL+c])
      );
    end
  end
endmodule
